// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared frame-buffer state encoding and address layout helpers
package hub75_pkg;

    // Write-side sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } fb_state_e;

    // Frame buffer address is {back_buf, y, x}; x occupies the low bits.
    function automatic int unsigned addr_x_lsb();
        return 0;
    endfunction

    function automatic int unsigned addr_y_lsb(input int unsigned x_bits);
        return x_bits;
    endfunction

    function automatic int unsigned addr_buf_bit(input int unsigned x_bits,
                                                 input int unsigned y_bits);
        return x_bits + y_bits;
    endfunction

endpackage

// File: rtl/pixel_addr_counter.sv
// rtl/pixel_addr_counter.sv - x/y raster counter with clear, increment and last-pixel flag
module pixel_addr_counter #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 32,
    parameter int X_BITS = $clog2(WIDTH),
    parameter int Y_BITS = $clog2(HEIGHT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [X_BITS-1:0] x_o,
    output logic [Y_BITS-1:0] y_o,
    output logic              last_o
);

    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(HEIGHT - 1);

    logic [X_BITS-1:0] x_q, x_d, cur_x;
    logic [Y_BITS-1:0] y_q, y_d, cur_y;

    // Clear takes effect in the same cycle, so a clear+increment writes at
    // (0,0) and leaves the counter pointing at the following pixel.
    always_comb begin
        cur_x = clr_i ? '0 : x_q;
        cur_y = clr_i ? '0 : y_q;
        x_d   = cur_x;
        y_d   = cur_y;
        if (inc_i) begin
            if (cur_x == X_MAX) begin
                x_d = '0;
                y_d = (cur_y == Y_MAX) ? '0 : cur_y + Y_BITS'(1);
            end else begin
                x_d = cur_x + X_BITS'(1);
            end
        end
        x_o    = cur_x;
        y_o    = cur_y;
        last_o = (cur_x == X_MAX) && (cur_y == Y_MAX);
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// rtl/fb_write_ctrl.sv - pixel stream to double-buffered frame buffer write sequencer
module fb_write_ctrl
    import hub75_pkg::*;
#(
    parameter int BITS_PER_PIXEL = 32,
    parameter int WIDTH          = 64,
    parameter int HEIGHT         = 32,
    parameter int X_BITS         = $clog2(WIDTH),
    parameter int Y_BITS         = $clog2(HEIGHT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pixel_valid,
    input  logic [BITS_PER_PIXEL-1:0]  pixel_data,
    input  logic                       frame_sync,
    input  logic                       swap_ack,
    input  logic                       overrun_clr,
    output logic                       fb_we,
    output logic [Y_BITS+X_BITS:0]     fb_addr,
    output logic [BITS_PER_PIXEL-1:0]  fb_wdata,
    output logic                       front_buf,
    output logic                       swap_req,
    output logic                       busy,
    output logic                       overrun
);

    localparam int unsigned X_LSB   = addr_x_lsb();
    localparam int unsigned Y_LSB   = addr_y_lsb(X_BITS);
    localparam int unsigned BUF_BIT = addr_buf_bit(X_BITS, Y_BITS);

    fb_state_e                   state_q;
    logic                        front_buf_q;
    logic                        swap_req_q;
    logic                        overrun_q;
    logic                        sync_pending_q;
    logic                        fb_we_q;
    logic [Y_BITS+X_BITS:0]      fb_addr_q;
    logic [BITS_PER_PIXEL-1:0]   fb_wdata_q;

    logic                        pix_accept;
    logic                        cnt_clr;
    logic [X_BITS-1:0]           cnt_x;
    logic [Y_BITS-1:0]           cnt_y;
    logic                        cnt_last;
    logic [Y_BITS+X_BITS:0]      wr_addr;

    pixel_addr_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (cnt_clr),
        .inc_i  (pix_accept),
        .x_o    (cnt_x),
        .y_o    (cnt_y),
        .last_o (cnt_last)
    );

    // Decide whether this cycle's pixel is written and whether the raster restarts;
    // frame_sync wins over a coincident pixel, which then lands at (0,0).
    always_comb begin
        pix_accept = 1'b0;
        cnt_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr    = frame_sync;
                pix_accept = frame_sync & pixel_valid;
            end
            ST_FILL: begin
                cnt_clr    = frame_sync;
                pix_accept = pixel_valid;
            end
            ST_WAIT_SWAP: begin
                cnt_clr = swap_ack;
            end
            default: ;
        endcase
    end

    // Writes always target the buffer that is not on display.
    always_comb begin
        wr_addr                      = '0;
        wr_addr[BUF_BIT]             = ~front_buf_q;
        wr_addr[Y_LSB +: Y_BITS]     = cnt_y;
        wr_addr[X_LSB +: X_BITS]     = cnt_x;
    end

    // Sequencer FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            front_buf_q    <= 1'b0;
            swap_req_q     <= 1'b0;
            overrun_q      <= 1'b0;
            sync_pending_q <= 1'b0;
            fb_we_q        <= 1'b0;
            fb_addr_q      <= '0;
            fb_wdata_q     <= '0;
        end else begin
            fb_we_q <= pix_accept;
            if (pix_accept) begin
                fb_addr_q  <= wr_addr;
                fb_wdata_q <= pixel_data;
            end

            // Clear first so a same-cycle overrun event below overrides it.
            if (overrun_clr) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (frame_sync) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: ;
                ST_WAIT_SWAP: begin
                    if (pixel_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (swap_ack) begin
                        front_buf_q    <= ~front_buf_q;
                        swap_req_q     <= 1'b0;
                        state_q        <= (sync_pending_q | frame_sync) ? ST_FILL : ST_IDLE;
                        sync_pending_q <= 1'b0;
                    end else if (frame_sync) begin
                        sync_pending_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // The final pixel's write and the swap request appear together.
            if (pix_accept && cnt_last) begin
                state_q    <= ST_WAIT_SWAP;
                swap_req_q <= 1'b1;
            end
        end
    end

    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_wdata  = fb_wdata_q;
    assign front_buf = front_buf_q;
    assign swap_req  = swap_req_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
